// File: rtl/cgra_pe_in_stream_if.sv
// Bus bundle for the CGRA input-PE stream controller.
// master: the pipeline/FIFO side that drives requests and config; slave: the controller.
interface cgra_pe_in_stream_if #(
    parameter int NUM_THREADS = 7,
    parameter int TID_WIDTH   = 3,
    parameter int DATA_WIDTH  = 32,
    parameter int IGN_WIDTH   = 16,
    parameter int QTD_WIDTH   = 64
);
    logic                   en;
    logic [TID_WIDTH-1:0]   conf_tid;
    logic [IGN_WIDTH-1:0]   ign_data;
    logic                   ign_we;
    logic [QTD_WIDTH-1:0]   qtd_data;
    logic                   qtd_we;
    logic                   clear;
    logic                   req;
    logic                   fifo_empty;
    logic [DATA_WIDTH-1:0]  fifo_data;
    logic                   fifo_re;
    logic                   stall;
    logic [TID_WIDTH-1:0]   thread_idx;
    logic [DATA_WIDTH-1:0]  data_out;
    logic                   data_valid;
    logic [TID_WIDTH-1:0]   data_tid;
    logic [NUM_THREADS-1:0] done;
    logic                   all_done;

    modport master (
        output en, conf_tid, ign_data, ign_we, qtd_data, qtd_we, clear, req,
        output fifo_empty, fifo_data,
        input  fifo_re, stall, thread_idx, data_out, data_valid, data_tid, done, all_done
    );

    modport slave (
        input  en, conf_tid, ign_data, ign_we, qtd_data, qtd_we, clear, req,
        input  fifo_empty, fifo_data,
        output fifo_re, stall, thread_idx, data_out, data_valid, data_tid, done, all_done
    );
endinterface

// File: rtl/cgra_pe_in_stream.sv
// Per-thread input-stream controller for the multithreaded CGRA input PE.
// Round-robin slot counter, per-thread ignore (skip) and quantity counters, FIFO pop gating,
// and registered delivery of the popped word with its thread tag.
// Build option: define PE_IN_STALL_EN to stall the current slot on an empty FIFO; otherwise
// an empty-FIFO pop slot is dropped and the slot counter keeps rotating.
module cgra_pe_in_stream #(
    parameter int NUM_THREADS = 7,
    parameter int TID_WIDTH   = 3,
    parameter int DATA_WIDTH  = 32,
    parameter int IGN_WIDTH   = 16,
    parameter int QTD_WIDTH   = 64
) (
    input logic                i_clk,
    input logic                i_rst_n,
    cgra_pe_in_stream_if.slave pe_bus
);

    logic [TID_WIDTH-1:0]   r_thread_idx;
    logic [IGN_WIDTH-1:0]   r_ign_lim [NUM_THREADS];
    logic [IGN_WIDTH-1:0]   r_ign_cnt [NUM_THREADS];
    logic [QTD_WIDTH-1:0]   r_qtd_lim [NUM_THREADS];
    logic [QTD_WIDTH-1:0]   r_qtd_cnt [NUM_THREADS];
    logic [DATA_WIDTH-1:0]  r_data_out;
    logic                   r_data_valid;
    logic [TID_WIDTH-1:0]   r_data_tid;

    logic                   w_act;
    logic                   w_skip;
    logic                   w_unlim;
    logic                   w_can_pop;
    logic                   w_pop_slot;
    logic                   w_fifo_re;
    logic                   w_stall;
    logic                   w_advance;
    logic                   w_ign_inc;
    logic                   w_qtd_inc;
    logic [NUM_THREADS-1:0] w_done;

    // Decode the current slot: skip has priority over pop, pop over exhausted.
    always_comb begin
        w_act      = pe_bus.en & pe_bus.req;
        w_skip     = r_ign_cnt[r_thread_idx] < r_ign_lim[r_thread_idx];
        w_unlim    = (r_qtd_lim[r_thread_idx] == '0);
        w_can_pop  = w_unlim | (r_qtd_cnt[r_thread_idx] < r_qtd_lim[r_thread_idx]);
        w_pop_slot = w_act & ~w_skip & w_can_pop;
        // Gated with reset so a pending pop is dropped as soon as reset asserts.
        w_fifo_re  = w_pop_slot & ~pe_bus.fifo_empty & i_rst_n;
`ifdef PE_IN_STALL_EN
        w_stall    = w_pop_slot & pe_bus.fifo_empty & i_rst_n;
`else
        w_stall    = 1'b0;
`endif
        w_advance  = pe_bus.en & ~w_stall;
        w_ign_inc  = w_act & w_skip;
        // Unlimited threads never count, so the counter cannot wrap.
        w_qtd_inc  = w_fifo_re & ~w_unlim;
    end

    // Per-thread quantity-exhausted flags from registered state.
    always_comb begin
        w_done = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            w_done[i] = (r_qtd_lim[i] != '0) && (r_qtd_cnt[i] == r_qtd_lim[i]);
        end
    end

    // Round-robin slot counter; holds while disabled or stalled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_thread_idx <= '0;
        end else if (w_advance) begin
            if (r_thread_idx == TID_WIDTH'(NUM_THREADS - 1)) begin
                r_thread_idx <= '0;
            end else begin
                r_thread_idx <= r_thread_idx + TID_WIDTH'(1);
            end
        end
    end

    // Limits and counters: clear beats increments, a config write beats both on its thread.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                r_ign_lim[i] <= '0;
                r_ign_cnt[i] <= '0;
                r_qtd_lim[i] <= '0;
                r_qtd_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                if (pe_bus.clear) begin
                    r_ign_cnt[i] <= '0;
                    r_qtd_cnt[i] <= '0;
                end else begin
                    if (w_ign_inc && (r_thread_idx == TID_WIDTH'(i))) begin
                        r_ign_cnt[i] <= r_ign_cnt[i] + IGN_WIDTH'(1);
                    end
                    if (w_qtd_inc && (r_thread_idx == TID_WIDTH'(i))) begin
                        r_qtd_cnt[i] <= r_qtd_cnt[i] + QTD_WIDTH'(1);
                    end
                end
                if (pe_bus.ign_we && (pe_bus.conf_tid == TID_WIDTH'(i))) begin
                    r_ign_lim[i] <= pe_bus.ign_data;
                    r_ign_cnt[i] <= '0;
                end
                if (pe_bus.qtd_we && (pe_bus.conf_tid == TID_WIDTH'(i))) begin
                    r_qtd_lim[i] <= pe_bus.qtd_data;
                    r_qtd_cnt[i] <= '0;
                end
            end
        end
    end

    // Capture the popped FIFO head and its owner; valid pulses once per pop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_data_tid   <= '0;
        end else begin
            r_data_valid <= w_fifo_re;
            if (w_fifo_re) begin
                r_data_out <= pe_bus.fifo_data;
                r_data_tid <= r_thread_idx;
            end
        end
    end

    assign pe_bus.fifo_re    = w_fifo_re;
    assign pe_bus.stall      = w_stall;
    assign pe_bus.thread_idx = r_thread_idx;
    assign pe_bus.data_out   = r_data_out;
    assign pe_bus.data_valid = r_data_valid;
    assign pe_bus.data_tid   = r_data_tid;
    assign pe_bus.done       = w_done;
    assign pe_bus.all_done   = &w_done;

endmodule

// File: tb/tb_cgra_pe_in_stream.sv
// Directed bench for cgra_pe_in_stream with a FIFO model and a data scoreboard.
module tb_cgra_pe_in_stream;
    localparam int NT = 7;

    logic clk;
    logic rst_n;

    cgra_pe_in_stream_if #(
        .NUM_THREADS(NT), .TID_WIDTH(3), .DATA_WIDTH(32), .IGN_WIDTH(16), .QTD_WIDTH(64)
    ) bus ();

    cgra_pe_in_stream #(
        .NUM_THREADS(NT), .TID_WIDTH(3), .DATA_WIDTH(32), .IGN_WIDTH(16), .QTD_WIDTH(64)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .pe_bus  (bus)
    );

    int tests_run;
    int tests_failed;

    // FIFO model: first-word-fall-through, popped on fifo_re at the clock edge.
    logic [31:0] mem [256];
    logic [7:0]  wr_ptr;
    logic [7:0]  rd_ptr;
    assign bus.fifo_empty = (rd_ptr == wr_ptr);
    assign bus.fifo_data  = mem[rd_ptr];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_ptr <= rd_ptr;
        else if (bus.fifo_re) rd_ptr <= rd_ptr + 8'd1;
    end

    // Scoreboard of expected (data, tid) pairs.
    logic [31:0] exp_data [$];
    logic [2:0]  exp_tid  [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900us;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.data_valid) begin
            tests_run++;
            assert (exp_data.size() != 0) else begin
                tests_failed++;
                $error("FAIL sb_unexpected: observed data %0h tid %0d required none",
                       bus.data_out, bus.data_tid);
            end
            if (exp_data.size() != 0) begin
                chk("sb_data", 64'(bus.data_out), 64'(exp_data.pop_front()));
                chk("sb_tid", 64'(bus.data_tid), 64'(exp_tid.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic expect_pop(input logic [31:0] w, input logic [2:0] t);
        exp_data.push_back(w);
        exp_tid.push_back(t);
    endtask

    task automatic wait_slot(input int t);
        int n;
        n = 0;
        while (bus.thread_idx != 3'(t) && n < 20) begin
            tick();
            n++;
        end
        chk("wait_slot", 64'(bus.thread_idx), 64'(t));
    endtask

    task automatic cfg_qtd(input int t, input logic [63:0] v);
        bus.conf_tid = 3'(t);
        bus.qtd_data = v;
        bus.qtd_we   = 1'b1;
        tick();
        bus.qtd_we   = 1'b0;
    endtask

    initial begin
        int s;
        tests_run = 0;
        tests_failed = 0;
        wr_ptr = '0;
        rd_ptr = '0;
        rst_n = 1'b0;
        bus.en = 1'b0;
        bus.conf_tid = '0;
        bus.ign_data = '0;
        bus.ign_we = 1'b0;
        bus.qtd_data = '0;
        bus.qtd_we = 1'b0;
        bus.clear = 1'b0;
        bus.req = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = '0;

        // Reset state
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_thread_idx", 64'(bus.thread_idx), 64'd0);
        chk("rst_data_valid", 64'(bus.data_valid), 64'd0);
        chk("rst_all_done", 64'(bus.all_done), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_data_out", 64'(bus.data_out), 64'd0);

        // Slot rotation 0..6,0
        bus.en = 1'b1;
        for (int k = 0; k <= NT; k++) begin
            chk("slot_seq", 64'(bus.thread_idx), 64'(k % NT));
            tick();
        end

        // Thread 2: skip 3, pop 2, then exhausted
        bus.en = 1'b0;
        bus.conf_tid = 3'd2;
        bus.ign_data = 16'd3;
        bus.ign_we = 1'b1;
        bus.qtd_data = 64'd2;
        bus.qtd_we = 1'b1;
        tick();
        bus.ign_we = 1'b0;
        bus.qtd_we = 1'b0;
        push(32'hA);
        push(32'hB);
        push(32'hC);
        bus.en = 1'b1;
        s = 0;
        for (int c = 0; c < 6 * NT; c++) begin
            bus.req = (bus.thread_idx == 3'd2);
            #1;
            if (bus.req) begin
                chk("t2_fifo_re", 64'(bus.fifo_re), 64'((s == 3) || (s == 4)));
                if (s == 3) expect_pop(32'hA, 3'd2);
                if (s == 4) expect_pop(32'hB, 3'd2);
                s++;
            end
            tick();
        end
        bus.req = 1'b0;
        chk("t2_slots_seen", 64'(s), 64'd6);
        chk("t2_done", 64'(bus.done), 64'h04);
        chk("t2_fifo_left", 64'(wr_ptr - rd_ptr), 64'd1);
        chk("t2_fifo_head", 64'(bus.fifo_data), 64'hC);

        // Reload thread 2 quantity and drain 0xC
        cfg_qtd(2, 64'd1);
        chk("t2_reload_done", 64'(bus.done), 64'h00);
        wait_slot(2);
        bus.req = 1'b1;
        #1;
        chk("t2_reload_re", 64'(bus.fifo_re), 64'd1);
        expect_pop(32'hC, 3'd2);
        tick();
        bus.req = 1'b0;
        chk("t2_reload_done2", 64'(bus.done), 64'h04);

        // Thread 1 pop slot on an empty FIFO
        cfg_qtd(1, 64'd1);
        wait_slot(1);
        bus.req = 1'b1;
        #1;
`ifdef PE_IN_STALL_EN
        for (int k = 0; k < 4; k++) begin
            chk("stall_on", 64'(bus.stall), 64'd1);
            chk("stall_idx", 64'(bus.thread_idx), 64'd1);
            chk("stall_re", 64'(bus.fifo_re), 64'd0);
            tick();
        end
        push(32'h55);
        #1;
        chk("stall_off", 64'(bus.stall), 64'd0);
        chk("stall_release_re", 64'(bus.fifo_re), 64'd1);
        expect_pop(32'h55, 3'd1);
        tick();
        bus.req = 1'b0;
        chk("stall_data_out", 64'(bus.data_out), 64'h55);
        chk("stall_data_valid", 64'(bus.data_valid), 64'd1);
        chk("stall_done1", 64'(bus.done[1]), 64'd1);
`else
        chk("nostall_stall", 64'(bus.stall), 64'd0);
        chk("nostall_re", 64'(bus.fifo_re), 64'd0);
        tick();
        chk("nostall_advance", 64'(bus.thread_idx), 64'd2);
        bus.req = 1'b0;
        chk("nostall_done1", 64'(bus.done[1]), 64'd0);
        push(32'h55);
        wait_slot(1);
        bus.req = 1'b1;
        #1;
        chk("nostall_pop_re", 64'(bus.fifo_re), 64'd1);
        expect_pop(32'h55, 3'd1);
        tick();
        bus.req = 1'b0;
        chk("nostall_data_out", 64'(bus.data_out), 64'h55);
        chk("nostall_done1b", 64'(bus.done[1]), 64'd1);
`endif

        // Unlimited thread 0: 1000 pops
        for (int k = 0; k < 1000; k++) begin
            wait_slot(0);
            push(32'h1000 + 32'(k));
            expect_pop(32'h1000 + 32'(k), 3'd0);
            bus.req = 1'b1;
            tick();
            bus.req = 1'b0;
        end
        chk("unlim_done0", 64'(bus.done[0]), 64'd0);

        // All threads quantity 1, one pop each
        bus.en = 1'b0;
        for (int t = 0; t < NT; t++) cfg_qtd(t, 64'd1);
        bus.en = 1'b1;
        for (int k = 0; k < NT; k++) push(32'h100 + 32'(k));
        wait_slot(0);
        for (int k = 0; k < NT; k++) begin
            chk("all_done_early", 64'(bus.all_done), 64'd0);
            bus.req = 1'b1;
            #1;
            chk("all_pop_re", 64'(bus.fifo_re), 64'd1);
            expect_pop(32'h100 + 32'(k), 3'(k));
            tick();
        end
        chk("all_done_mask", 64'(bus.done), 64'h7f);
        chk("all_done", 64'(bus.all_done), 64'd1);
        push(32'h1FF);
        #1;
        chk("exhausted_re", 64'(bus.fifo_re), 64'd0);
        bus.req = 1'b0;
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        chk("clear_done", 64'(bus.done), 64'h00);
        chk("clear_all_done", 64'(bus.all_done), 64'd0);
        wait_slot(4);
        bus.req = 1'b1;
        #1;
        chk("clear_pop_re", 64'(bus.fifo_re), 64'd1);
        expect_pop(32'h1FF, 3'd4);
        tick();
        bus.req = 1'b0;
        chk("clear_limit_kept", 64'(bus.done), 64'h10);

        // Config write on thread 3 overrides same-cycle pop count
        push(32'h33);
        wait_slot(3);
        bus.req = 1'b1;
        bus.conf_tid = 3'd3;
        bus.qtd_data = 64'd1;
        bus.qtd_we = 1'b1;
        #1;
        chk("ovr_re", 64'(bus.fifo_re), 64'd1);
        expect_pop(32'h33, 3'd3);
        tick();
        bus.req = 1'b0;
        bus.qtd_we = 1'b0;
        chk("ovr_done", 64'(bus.done), 64'h10);
        push(32'h34);
        wait_slot(3);
        bus.req = 1'b1;
        #1;
        chk("ovr_pop2_re", 64'(bus.fifo_re), 64'd1);
        expect_pop(32'h34, 3'd3);
        tick();
        bus.req = 1'b0;
        chk("ovr_done2", 64'(bus.done), 64'h18);

        // en=0 freezes the slot; reset mid-stream drops the pop
        push(32'h77);
        wait_slot(5);
        bus.en = 1'b0;
        bus.req = 1'b1;
        #1;
        chk("en0_re", 64'(bus.fifo_re), 64'd0);
        chk("en0_stall", 64'(bus.stall), 64'd0);
        tick();
        chk("en0_hold", 64'(bus.thread_idx), 64'd5);
        bus.en = 1'b1;
        #1;
        chk("en1_re", 64'(bus.fifo_re), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_re", 64'(bus.fifo_re), 64'd0);
        chk("rst_mid_idx", 64'(bus.thread_idx), 64'd0);
        chk("rst_mid_done", 64'(bus.done), 64'h00);
        tick();
        bus.req = 1'b0;
        rst_n = 1'b1;
        chk("rst_mid_fifo_kept", 64'(wr_ptr - rd_ptr), 64'd1);
        tick();
        tick();
        chk("sb_drained", 64'(exp_data.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
